// File: rtl/scpu_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//
// Contents:
//   uart_state_t  - transmitter FSM state encoding (2 bits, or 3 bits when
//                   UART_TX_PARITY_EN adds the PARITY state)
//   REG_DATA      - offset of the DATA register from the block base address
//   REG_STATUS    - offset of the STATUS register from the block base address
//   STAT_*        - bit positions inside the STATUS register
//   satCount      - clamps a FIFO occupancy to the 4-bit STATUS count field
//
// Optional feature macro: UART_TX_PARITY_EN
package scpu_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;
`endif

  localparam logic [15:0] REG_DATA   = 16'd0;
  localparam logic [15:0] REG_STATUS = 16'd1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  // A 16-deep FIFO can hold 16 bytes, which does not fit the 4-bit field,
  // so the reported count sticks at 15.
  function automatic logic [3:0] satCount(input logic [4:0] cnt);
    return (cnt > 5'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   i_push      - write i_wdata; accepted when not full, or when full and
//                 a pop happens on the same edge
//   i_pop       - discard the head entry; ignored when empty
//   i_wdata     - write data
//   o_rdata     - current head entry (valid while o_empty is low)
//   o_full      - DEPTH entries stored
//   o_empty     - no entries stored
//   o_count     - number of entries stored, $clog2(DEPTH)+1 bits
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_DEPTH = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wptr <= r_wptr + PTR_ONE;
      if (w_doPop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; reset only has to make the contents unreachable.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == CNT_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped serial transmitter on the shared CPU buses.
//
// Registers:
//   BASE_ADDR+0 DATA   - write pushes a byte into the FIFO, read returns 0
//   BASE_ADDR+1 STATUS - {count[3:0], overflow, empty, full, busy};
//                        reading clears the sticky overflow bit
//
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   addr       - shared address bus
//   in_data    - shared write data bus
//   out_data   - read data, 8'h00 whenever this block is not driving
//   ce, w, r   - chip enable, write strobe, read strobe
//   oe         - output enable for the read data latched one cycle earlier
//   tx         - serial line, idle high, LSB-first frames
//
// Optional feature macro: UART_TX_PARITY_EN (adds an even parity bit,
// giving 11-bit frames instead of 8N1).
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 234,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  in_data,
  output logic [7:0]  out_data,
  input  logic        ce,
  input  logic        w,
  input  logic        r,
  input  logic        oe,
  output logic        tx
);

  import scpu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE    = 1;
  localparam logic [15:0]   DATA_ADDR   = BASE_ADDR + REG_DATA;
  localparam logic [15:0]   STATUS_ADDR = BASE_ADDR + REG_STATUS;

  uart_state_t r_state;
  uart_state_t w_stateNext;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baudNext;
  logic [2:0]    r_bitIdx;
  logic [2:0]    w_bitNext;
  logic [7:0]    r_shift;
  logic [7:0]    w_shiftNext;
  logic          r_tx;
  logic          w_txNext;
  logic          r_ovf;
  logic [7:0]    r_rdLatch;
  logic          r_rdHit;
`ifdef UART_TX_PARITY_EN
  logic          r_parity;
  logic          w_parityNext;
`endif

  logic          w_isData;
  logic          w_isStatus;
  logic          w_sel;
  logic          w_wrData;
  logic          w_rd;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_fifoData;
  logic [7:0]    w_status;
  logic          w_baudEnd;

  // Bus decode. A write wins over a simultaneous read, so the read is dropped.
  assign w_isData   = (addr == DATA_ADDR);
  assign w_isStatus = (addr == STATUS_ADDR);
  assign w_sel      = ce && (w_isData || w_isStatus);
  assign w_wrData   = w_sel && w && w_isData;
  assign w_rd       = w_sel && r && !w;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_wrData),
    .i_pop   (w_pop),
    .i_wdata (in_data),
    .o_rdata (w_fifoData),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_status                            = '0;
    w_status[STAT_BUSY]                 = (r_state != ST_IDLE);
    w_status[STAT_FULL]                 = w_full;
    w_status[STAT_EMPTY]                = w_empty;
    w_status[STAT_OVF]                  = r_ovf;
    w_status[STAT_CNT_LSB +: 4]         = satCount(5'(w_count));
  end

  // Overflow only when a full FIFO loses the byte, i.e. no pop frees a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_wrData && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_rd && w_isStatus) begin
      r_ovf <= 1'b0;
    end
  end

  // The read latch captures the pre-clear STATUS; the hit flag tracks whether
  // the most recent bus cycle was a read of this block, so out_data stays 0
  // while memory or another responder is being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdLatch <= 8'h00;
      r_rdHit   <= 1'b0;
    end else begin
      r_rdHit <= w_rd;
      if (w_rd) r_rdLatch <= w_isStatus ? w_status : 8'h00;
    end
  end

  assign out_data = (oe && r_rdHit) ? r_rdLatch : 8'h00;

  assign w_baudEnd = (r_baud == BAUD_LAST);

  // Next-state logic. The tx level is derived from the state being entered
  // so the registered pin changes on the same edge as the state.
  always_comb begin
    w_stateNext  = r_state;
    w_baudNext   = r_baud;
    w_bitNext    = r_bitIdx;
    w_shiftNext  = r_shift;
    w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parityNext = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shiftNext  = w_fifoData;
          w_baudNext   = '0;
          w_bitNext    = '0;
`ifdef UART_TX_PARITY_EN
          w_parityNext = ^w_fifoData;
`endif
          w_stateNext  = ST_START;
        end
      end
      ST_START: begin
        if (w_baudEnd) begin
          w_baudNext  = '0;
          w_stateNext = ST_DATA;
        end else begin
          w_baudNext  = r_baud + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (w_baudEnd) begin
          w_baudNext  = '0;
          w_shiftNext = {1'b0, r_shift[7:1]};
          if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_stateNext = ST_PARITY;
`else
            w_stateNext = ST_STOP;
`endif
          end else begin
            w_bitNext = r_bitIdx + 3'd1;
          end
        end else begin
          w_baudNext = r_baud + BAUD_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_baudEnd) begin
          w_baudNext  = '0;
          w_stateNext = ST_STOP;
        end else begin
          w_baudNext  = r_baud + BAUD_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (w_baudEnd) begin
          w_baudNext  = '0;
          w_stateNext = ST_IDLE;
        end else begin
          w_baudNext  = r_baud + BAUD_ONE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_baudNext  = '0;
      end
    endcase

    case (w_stateNext)
      ST_START:  w_txNext = 1'b0;
      ST_DATA:   w_txNext = w_shiftNext[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_txNext = w_parityNext;
`endif
      default:   w_txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= 8'h00;
      r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_stateNext;
      r_baud   <= w_baudNext;
      r_bitIdx <= w_bitNext;
      r_shift  <= w_shiftNext;
      r_tx     <= w_txNext;
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parityNext;
`endif
    end
  end

  assign tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A transaction-level model (byte queue, frame start time, sticky flag)
// predicts tx and out_data every cycle; directed checks cover the
// reset, overflow, decode, latency and mid-frame reset cases.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hFF00;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] addr    = 16'h0000;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  out_data;
  logic        ce      = 1'b0;
  logic        w       = 1'b0;
  logic        r       = 1'b0;
  logic        oe      = 1'b0;
  logic        tx;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .in_data  (in_data),
    .out_data (out_data),
    .ce       (ce),
    .w        (w),
    .r        (r),
    .oe       (oe),
    .tx       (tx)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%02h expected=%02h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Reference model state
  int          edgeNum = 0;
  int          mPop    = -100000;
  logic [7:0]  mQ[$];
  logic [7:0]  mCur    = 8'h00;
  bit          mOvf    = 1'b0;
  logic [7:0]  mLatch  = 8'h00;
  bit          mHit    = 1'b0;
  bit          mBusy   = 1'b0;
  bit          mSel, mRd, mWr, mDoPop;
  bit          checkEn = 1'b0;

  function automatic logic [7:0] modelStatus();
    int n;
    logic [7:0] s;
    n    = mQ.size();
    s    = 8'h00;
    s[7:4] = (n > 15) ? 4'hF : 4'(n);
    s[3] = mOvf;
    s[2] = (n == 0);
    s[1] = (n == DEPTH);
    s[0] = mBusy;
    return s;
  endfunction

  function automatic logic modelTx();
    int k;
    if (!mBusy) return 1'b1;
    k = (edgeNum - mPop) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return mCur[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^mCur;
`endif
    return 1'b1;
  endfunction

  // One model step per clock edge: read uses pre-edge state, then a frame
  // may start (one frame per FRAME_CYC+1 edges), then the write lands.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mQ.delete();
      mPop   = -100000;
      mOvf   = 1'b0;
      mLatch = 8'h00;
      mHit   = 1'b0;
      mBusy  = 1'b0;
    end else begin
      edgeNum++;
      mSel = ce && (addr == BASE || addr == BASE + 16'd1);
      mRd  = mSel && r && !w;
      mWr  = mSel && w && (addr == BASE);
      mHit = mRd;
      if (mRd) begin
        mLatch = (addr == BASE + 16'd1) ? modelStatus() : 8'h00;
        if (addr == BASE + 16'd1) mOvf = 1'b0;
      end
      mDoPop = (mQ.size() > 0) && (edgeNum >= mPop + FRAME_CYC + 1);
      if (mDoPop) begin
        mCur = mQ.pop_front();
        mPop = edgeNum;
      end
      if (mWr) begin
        if (mQ.size() < DEPTH) mQ.push_back(in_data);
        else                   mOvf = 1'b1;
      end
      mBusy = (edgeNum - mPop) < FRAME_CYC;
    end
  end

  always @(negedge clk) begin
    if (rst_n && checkEn) begin
      checkOutput("tx", {7'b0, tx}, {7'b0, modelTx()});
      checkOutput("out_data", out_data, (oe && mHit) ? mLatch : 8'h00);
    end
  end

  // Drive one bus cycle, then advance to 2 time units after the next edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                               input logic iCe, input logic iW,
                               input logic iR, input logic iOe);
    addr    = a;
    in_data = d;
    ce      = iCe;
    w       = iW;
    r       = iR;
    oe      = iOe;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic readReg(input logic [15:0] a, output logic [7:0] v);
    applyStimulus(a, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    addr = 16'h0000;
    ce   = 1'b0;
    r    = 1'b0;
    oe   = 1'b1;
    #4;
    v = out_data;
    @(posedge clk);
    #2;
    oe = 1'b0;
  endtask

  logic [7:0]  v;
  logic [15:0] ra;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #2;
    checkOutput("resetTx", {7'b0, tx}, 8'h01);
    checkOutput("resetOut", out_data, 8'h00);
    rst_n   = 1'b1;
    checkEn = 1'b1;
    idle(2);
    readReg(BASE + 16'd1, v);
    checkOutput("resetStatus", v, 8'h04);

    // Single byte
    applyStimulus(BASE, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    readReg(BASE + 16'd1, v);
    checkOutput("busyStatus", v, 8'h05);
    idle(FRAME_CYC);
    readReg(BASE + 16'd1, v);
    checkOutput("idleStatus", v, 8'h04);

    // Overflow: one popped, four queued, one dropped
    for (int i = 0; i < 6; i++)
      applyStimulus(BASE, 8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
    readReg(BASE + 16'd1, v);
    checkOutput("ovfStatus", v, 8'h4B);
    readReg(BASE + 16'd1, v);
    checkOutput("ovfCleared", v, 8'h43);
    idle(6 * (FRAME_CYC + 1));
    readReg(BASE + 16'd1, v);
    checkOutput("drainStatus", v, 8'h04);

    // Unselected address
    applyStimulus(16'hFEFF, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    readReg(16'hFEFF, v);
    checkOutput("unselOut", v, 8'h00);
    idle(FRAME_CYC);
    readReg(BASE + 16'd1, v);
    checkOutput("unselStatus", v, 8'h04);
    readReg(BASE, v);
    checkOutput("dataRead", v, 8'h00);

    // Read latency: r and oe together, then oe alone, then oe held
    idle(1);
    addr = BASE + 16'd1; ce = 1'b1; r = 1'b1; oe = 1'b1;
    #4;
    checkOutput("latSameCycle", out_data, 8'h00);
    @(posedge clk); #2;
    addr = 16'h0000; ce = 1'b0; r = 1'b0;
    #4;
    checkOutput("latNext", out_data, 8'h04);
    @(posedge clk); #2;
    #4;
    checkOutput("latAfter", out_data, 8'h00);
    @(posedge clk); #2;
    oe = 1'b0;

    // Write and read together: the write wins
    applyStimulus(BASE, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    oe = 1'b1;
    #4;
    checkOutput("wrRdOut", out_data, 8'h00);
    @(posedge clk); #2;
    oe = 1'b0;
    idle(FRAME_CYC + 2);

    // Randomized bus traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: ra = BASE;
        3:       ra = BASE + 16'd1;
        4:       ra = 16'hFEFF;
        default: ra = BASE + 16'd2;
      endcase
      applyStimulus(ra, 8'($urandom), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 1));
    end
    idle((DEPTH + 1) * (FRAME_CYC + 1) + 5);

    // Reset during data bit 3 of a frame carrying 8'hF7
    applyStimulus(BASE, 8'hF7, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(18);
    checkOutput("txBit3", {7'b0, tx}, 8'h00);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncTx", {7'b0, tx}, 8'h01);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    readReg(BASE + 16'd1, v);
    checkOutput("postResetStatus", v, 8'h04);
    idle(FRAME_CYC + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
